// File: rtl/fetch_sequencer.sv
// Program counter / fetch controller for the 9-bit instruction ROM with a valid/ready issue port.
// Optional performance counters are built when FETCH_SEQ_PERF_EN is defined.
module fetch_sequencer #(
    parameter int unsigned     PC_W      = 16,
    parameter int unsigned     PROG_LEN  = 35,
    parameter logic [8:0]      HALT_WORD = 9'h1FF,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    output logic [PC_W-1:0] pc_out,
    input  logic            rom_format,
    input  logic [3:0]      rom_opcode,
    input  logic            rom_sign,
    input  logic [2:0]      rom_operand,
    input  logic [7:0]      rom_immediate,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [PC_W-1:0] issue_pc,
    output logic            issue_format,
    output logic [3:0]      issue_opcode,
    output logic            issue_sign,
    output logic [2:0]      issue_operand,
    output logic [7:0]      issue_immediate,
    input  logic            br_taken,
    input  logic [PC_W-1:0] br_target,
    output logic            busy,
    output logic            halted,
    output logic [15:0]     perf_issued,
    output logic [15:0]     perf_stalls
);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2} state_t;

    typedef struct packed {
        logic       format;
        logic [3:0] opcode;
        logic       sign;
        logic [2:0] operand;
        logic [7:0] immediate;
    } instr_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    instr_t          ir;
    instr_t          rom_instr;
    logic            fire;
    logic            load;
    logic            at_end;
    logic            restart;

    assign rom_instr = {rom_format, rom_opcode, rom_sign, rom_operand, rom_immediate};
    assign fire      = issue_valid & issue_ready;
    assign load      = (state == S_RUN) & (~issue_valid | fire) & ~br_taken;
    assign restart   = start & (state != S_RUN);
    // End of program: either ran off the end or fetched the halt word (never issued).
    assign at_end    = (32'(pc) >= PROG_LEN) | ({rom_format, rom_immediate} == HALT_WORD);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            issue_valid <= 1'b0;
            issue_pc    <= '0;
            ir          <= '0;
            busy        <= 1'b0;
            halted      <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_HALT: begin
                    if (start) begin
                        state       <= S_RUN;
                        pc          <= RESET_PC;
                        issue_valid <= 1'b0;
                        busy        <= 1'b1;
                        halted      <= 1'b0;
                    end
                end
                S_RUN: begin
                    // A redirect drops the held instruction even if it fires this cycle.
                    if (br_taken) begin
                        pc          <= br_target;
                        issue_valid <= 1'b0;
                    end else if (load && at_end) begin
                        issue_valid <= 1'b0;
                        state       <= S_HALT;
                        busy        <= 1'b0;
                        halted      <= 1'b1;
                    end else if (load) begin
                        ir          <= rom_instr;
                        issue_pc    <= pc;
                        issue_valid <= 1'b1;
                        pc          <= pc + PC_W'(1);
                    end
                end
                default: begin
                    state       <= S_IDLE;
                    issue_valid <= 1'b0;
                    busy        <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

    assign pc_out          = pc;
    assign issue_format    = ir.format;
    assign issue_opcode    = ir.opcode;
    assign issue_sign      = ir.sign;
    assign issue_operand   = ir.operand;
    assign issue_immediate = ir.immediate;

`ifdef FETCH_SEQ_PERF_EN
    logic [15:0] issued_q;
    logic [15:0] stalls_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            issued_q <= '0;
            stalls_q <= '0;
        end else if (restart) begin
            issued_q <= '0;
            stalls_q <= '0;
        end else if (state == S_RUN) begin
            if (fire && !br_taken && issued_q != 16'hFFFF)
                issued_q <= issued_q + 16'd1;
            if (issue_valid && !issue_ready && stalls_q != 16'hFFFF)
                stalls_q <= stalls_q + 16'd1;
        end
    end

    assign perf_issued = issued_q;
    assign perf_stalls = stalls_q;
`else
    assign perf_issued = '0;
    assign perf_stalls = '0;
`endif

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_sequencer;
    localparam int IDLE = 0, RUN = 1, HALT = 2;

    logic        clk = 1'b0;
    logic        reset_n, start, issue_ready, br_taken;
    logic [15:0] br_target, pc_out, issue_pc;
    logic        rom_format, rom_sign, issue_valid, issue_format, issue_sign, busy, halted;
    logic [3:0]  rom_opcode, issue_opcode;
    logic [2:0]  rom_operand, issue_operand;
    logic [7:0]  rom_immediate, issue_immediate;
    logic [15:0] perf_issued, perf_stalls;

    logic [8:0]  rom [64];
    logic [8:0]  rom_word;

    int          checks = 0;
    int          errors = 0;

    // behavioural model state
    int          m_state;
    logic [15:0] m_pc, m_ipc;
    logic        m_valid;
    logic [8:0]  m_ir;
    int          m_issued, m_stalls;
    int          acc[$];

    always #5 clk = ~clk;

    assign rom_word      = (pc_out < 16'd64) ? rom[pc_out[5:0]] : 9'h0;
    assign rom_format    = rom_word[8];
    assign rom_opcode    = rom_word[7:4];
    assign rom_sign      = rom_word[3];
    assign rom_operand   = rom_word[2:0];
    assign rom_immediate = rom_word[7:0];

    fetch_sequencer dut (
        .clk(clk), .reset_n(reset_n), .start(start), .pc_out(pc_out),
        .rom_format(rom_format), .rom_opcode(rom_opcode), .rom_sign(rom_sign),
        .rom_operand(rom_operand), .rom_immediate(rom_immediate),
        .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_pc(issue_pc),
        .issue_format(issue_format), .issue_opcode(issue_opcode), .issue_sign(issue_sign),
        .issue_operand(issue_operand), .issue_immediate(issue_immediate),
        .br_taken(br_taken), .br_target(br_target), .busy(busy), .halted(halted),
        .perf_issued(perf_issued), .perf_stalls(perf_stalls)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [8:0] rand_word();
        logic [8:0] w;
        w = 9'($urandom_range(0, 511));
        return (w == 9'h1FF) ? 9'h1FE : w;
    endfunction

    task automatic model_reset();
        m_state = IDLE; m_pc = 16'd0; m_ipc = 16'd0; m_valid = 1'b0; m_ir = 9'h0;
        m_issued = 0; m_stalls = 0;
    endtask

    // One cycle of the program-level rules, evaluated on the inputs present before the edge.
    task automatic model_step();
        logic       fire;
        logic [8:0] w;
        fire = m_valid && issue_ready;
        if (m_state == RUN) begin
            if (fire && !br_taken && m_issued < 65535) m_issued++;
            if (m_valid && !issue_ready && m_stalls < 65535) m_stalls++;
            if (br_taken) begin
                m_pc = br_target; m_valid = 1'b0;
            end else if (!m_valid || fire) begin
                w = (m_pc < 16'd64) ? rom[m_pc[5:0]] : 9'h0;
                if (m_pc >= 16'd35 || w == 9'h1FF) begin
                    m_valid = 1'b0; m_state = HALT;
                end else begin
                    m_ir = w; m_ipc = m_pc; m_valid = 1'b1; m_pc = m_pc + 16'd1;
                end
            end
        end else if (start) begin
            m_state = RUN; m_pc = 16'd0; m_valid = 1'b0; m_issued = 0; m_stalls = 0;
        end
    endtask

    task automatic chk_all();
        chk("pc_out",    32'(pc_out),          32'(m_pc));
        chk("valid",     32'(issue_valid),     32'(m_valid));
        chk("issue_pc",  32'(issue_pc),        32'(m_ipc));
        chk("format",    32'(issue_format),    32'(m_ir[8]));
        chk("opcode",    32'(issue_opcode),    32'(m_ir[7:4]));
        chk("sign",      32'(issue_sign),      32'(m_ir[3]));
        chk("operand",   32'(issue_operand),   32'(m_ir[2:0]));
        chk("immediate", 32'(issue_immediate), 32'(m_ir[7:0]));
        chk("busy",      32'(busy),            32'(m_state == RUN));
        chk("halted",    32'(halted),          32'(m_state == HALT));
`ifdef FETCH_SEQ_PERF_EN
        chk("perf_issued", 32'(perf_issued), 32'(m_issued));
        chk("perf_stalls", 32'(perf_stalls), 32'(m_stalls));
`else
        chk("perf_issued", 32'(perf_issued), 32'd0);
        chk("perf_stalls", 32'(perf_stalls), 32'd0);
`endif
    endtask

    task automatic cycle();
        if (issue_valid && issue_ready && !br_taken) acc.push_back(int'(issue_pc));
        model_step();
        @(posedge clk);
        #1;
        chk_all();
    endtask

    task automatic run_until_ipc(input int pc);
        for (int i = 0; i < 40; i++) begin
            if (m_valid && m_ipc == 16'(pc)) break;
            cycle();
        end
        chk("reach_ipc", 32'(issue_valid && issue_pc == 16'(pc)), 32'd1);
    endtask

    task automatic run_until_halt();
        for (int i = 0; i < 60; i++) begin
            if (m_state == HALT) break;
            cycle();
        end
        chk("reach_halt", 32'(halted), 32'd1);
    endtask

    task automatic pulse_start();
        start = 1'b1; cycle(); start = 1'b0;
    endtask

    initial begin
        logic [8:0] saved;
        reset_n = 1'b0; start = 1'b0; issue_ready = 1'b0; br_taken = 1'b0; br_target = 16'd0;
        for (int i = 0; i < 64; i++) rom[i] = rand_word();
        model_reset();
        #1;
        chk_all();
        #11 reset_n = 1'b1;
        cycle(); cycle();

        // full program, ready always high
        issue_ready = 1'b1;
        pulse_start();
        chk("lat_n1_valid", 32'(issue_valid), 32'd0);
        cycle();
        chk("lat_n2_valid", 32'(issue_valid), 32'd1);
        chk("lat_n2_pc",    32'(issue_pc),    32'd0);
        run_until_halt();
        chk("end_pc_out", 32'(pc_out), 32'd35);
        chk("end_count",  32'(acc.size()), 32'd35);
        for (int i = 0; i < acc.size() && i < 35; i++) chk("end_seq", 32'(acc[i]), 32'(i));
`ifdef FETCH_SEQ_PERF_EN
        chk("end_perf_issued", 32'(perf_issued), 32'd35);
`endif
        cycle(); cycle();
        chk("halt_no_issue", 32'(issue_valid), 32'd0);

        // stall at PC 5
        acc.delete();
        pulse_start();
        run_until_ipc(5);
        issue_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_ipc", 32'(issue_pc), 32'd5);
            chk("stall_pc",  32'(pc_out),   32'd6);
        end
`ifdef FETCH_SEQ_PERF_EN
        chk("stall_perf", 32'(perf_stalls), 32'd3);
`endif
        issue_ready = 1'b1;
        cycle();
        chk("stall_resume", 32'(issue_pc), 32'd6);

        // redirect to 20 while PC 9 is offered
        run_until_ipc(9);
        br_taken = 1'b1; br_target = 16'd20;
        cycle();
        br_taken = 1'b0;
        chk("br_bubble", 32'(issue_valid), 32'd0);
        chk("br_pc_out", 32'(pc_out), 32'd20);
        cycle();
        chk("br_first_v",  32'(issue_valid), 32'd1);
        chk("br_first_pc", 32'(issue_pc), 32'd20);
        cycle();
        chk("br_second_pc", 32'(issue_pc), 32'd21);
        chk("br_acc_len",  32'(acc.size()), 32'd10);
        chk("br_acc_last", 32'(acc[$]), 32'd20);
        chk("br_no_pc9",   32'(acc.find_first_index(x) with (x == 9).size()), 32'd0);

        // halt word at PC 4
        reset_n = 1'b0; #1; model_reset(); chk_all(); reset_n = 1'b1;
        saved = rom[4]; rom[4] = 9'h1FF;
        acc.delete();
        pulse_start();
        run_until_halt();
        chk("hw_count", 32'(acc.size()), 32'd4);
        for (int i = 0; i < acc.size() && i < 4; i++) chk("hw_seq", 32'(acc[i]), 32'(i));
        chk("hw_busy",  32'(busy), 32'd0);
        chk("hw_pc",    32'(pc_out), 32'd4);
        rom[4] = saved;
        pulse_start();
        cycle();
        chk("restart_v",  32'(issue_valid), 32'd1);
        chk("restart_pc", 32'(issue_pc), 32'd0);

        // async reset mid-run at PC 12
        run_until_ipc(12);
        #2 reset_n = 1'b0;
        #1 model_reset();
        chk("rst_valid", 32'(issue_valid), 32'd0);
        chk("rst_pc",    32'(pc_out), 32'd0);
        chk("rst_busy",  32'(busy), 32'd0);
        chk_all();
        #3 reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("rst_idle_v", 32'(issue_valid), 32'd0);
        end

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            issue_ready = ($urandom_range(0, 3) != 0);
            br_taken    = ($urandom_range(0, 9) == 0);
            br_target   = 16'($urandom_range(0, 36));
            start       = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 7) == 0)
                rom[$urandom_range(0, 40)] = ($urandom_range(0, 11) == 0) ? 9'h1FF : rand_word();
            cycle();
        end
        start = 1'b0; br_taken = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Program-counter and fetch controller for the 9-bit instruction ROM.
- Drives the ROM address and latches the decoded ROM fields into an instruction register.
- Presents each instruction to decode/execute over a valid/ready handshake.
- Handles branch redirects, program-end/halt detection and restart.

Parameters:
PC_W, 16, width of PC and branch target; ROM address is the zero-extended PC.
PROG_LEN, 35, first PC past the program; fetching at this PC ends the program.
HALT_WORD, 9'h1FF, 9-bit instruction word {format, immediate} that ends the program; it is never issued.
RESET_PC, 0, PC loaded on reset and on start.

Ports:
clk  in  1  clock, rising edge
reset_n  in  1  asynchronous active-low reset
start  in  1  pulse; leaves IDLE/HALT and restarts at RESET_PC
pc_out  out  PC_W  ROM address (registered PC)
rom_format  in  1  ROM format bit
rom_opcode  in  4  ROM opcode field
rom_sign  in  1  ROM sign bit
rom_operand  in  3  ROM operand field
rom_immediate  in  8  ROM immediate field (= instruction bits 7:0)
issue_valid  out  1  instruction register holds an unconsumed instruction
issue_ready  in  1  consumer accepts this cycle
issue_pc  out  PC_W  PC of the issued instruction
issue_format/issue_opcode/issue_sign/issue_operand/issue_immediate  out  1/4/1/3/8  registered copies of the ROM fields
br_taken  in  1  redirect request from execute
br_target  in  PC_W  redirect address
busy  out  1  state is RUN
halted  out  1  state is HALT
perf_issued  out  16  issued-instruction count (optional feature)
perf_stalls  out  16  stall-cycle count (optional feature)

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, pc=RESET_PC.
  - issue_valid=0; issue_* fields=0, issue_pc=0.
  - busy=0, halted=0, perf counters=0.
- ROM is combinational: fields present in the same cycle as pc_out.
- fire = issue_valid & issue_ready.
- load = state RUN & (!issue_valid | fire) & !br_taken.
- State IDLE:
  - start -> RUN; pc=RESET_PC; issue_valid=0.
- State RUN, priority order:
  1. br_taken: pc<=br_target; issue_valid<=0. The current IR content is discarded even if fire this cycle; the consumer must not count a same-cycle fire as accepted. Redirect penalty is exactly 1 bubble: first target instruction is valid 2 cycles after the br_taken cycle.
  2. load and (pc>=PROG_LEN or {rom_format,rom_immediate}==HALT_WORD): issue_valid<=0; state<=HALT; pc holds.
  3. load otherwise: IR<=ROM fields; issue_pc<=pc; issue_valid<=1; pc<=pc+1 (wraps modulo 2^PC_W).
  4. issue_valid & !issue_ready: IR, pc and issue_valid hold (stall).
- Throughput: one instruction per cycle while issue_ready=1.
- Latency: start in cycle N gives first issue_valid in cycle N+2 (N+1 pc=RESET_PC load; valid N+2).
- State HALT:
  - halted=1, issue_valid=0.
  - br_taken ignored; start -> RUN at RESET_PC.
- start while in RUN is ignored.
- Simultaneous start & br_taken in IDLE/HALT: start wins, branch ignored.
- Reset asserted mid-RUN clears everything immediately (asynchronously); no instruction is issued until a new start.
- busy = (state==RUN); halted = (state==HALT); both registered outputs of the state.

Optional Feature:
- Macro: FETCH_SEQ_PERF_EN.
- Defined:
  - perf_issued increments on each fire not coincident with br_taken.
  - perf_stalls increments each RUN cycle with issue_valid & !issue_ready.
  - Both saturate at 16'hFFFF and clear on reset and on start.
- Undefined: no counter logic; perf_issued and perf_stalls tied to 0. Ports exist in both builds.

Test Plan:
- Reset then start, issue_ready=1, ROM model of 35 words (PROG_LEN=35) -> issue_pc 0..34 on consecutive cycles, first valid 2 cycles after start, then halted=1 with pc_out=35 and no issue of PC 35.
- issue_ready held low 3 cycles while issue_pc=5 -> issue_pc stays 5, fields stable, pc_out stays 6, perf_stalls=3 (macro on); resumes with issue_pc 6.
- br_taken with br_target=20 while issue_pc=9 and issue_ready=1 -> PC 9 not counted, one bubble, next issue_pc=20, then 21.
- ROM word at PC 4 = 9'h1FF -> PCs 0..3 issued, PC 4 never issued, halted=1, busy=0; start -> restart at issue_pc=0.
- reset_n pulsed low mid-RUN at issue_pc=12 -> issue_valid=0, pc_out=0, busy=0 immediately; no issue until start.
- Macro off: perf_issued=perf_stalls=0 throughout the first scenario; macro on: perf_issued=35 at halt.
